// File: rtl/aftab_mdu_pkg.sv
// Shared encodings and op-decode helpers for the AFTAB multiply/divide unit.
package aftab_mdu_pkg;

   // funct3-style op codes
   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Ops in the same class produce the same hi/lo (or rem/quo) pair,
   // so one cached entry serves every op of that class.
   typedef enum logic [2:0] {
      CLS_MUL_SS = 3'd0,
      CLS_MUL_SU = 3'd1,
      CLS_MUL_UU = 3'd2,
      CLS_DIV_S  = 3'd3,
      CLS_DIV_U  = 3'd4
   } cls_t;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic a_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
             (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic b_signed(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic cls_t op_class(input logic [2:0] op);
      cls_t c;
      case (op)
         OP_MUL, OP_MULH: c = CLS_MUL_SS;
         OP_MULHSU:       c = CLS_MUL_SU;
         OP_MULHU:        c = CLS_MUL_UU;
         OP_DIV, OP_REM:  c = CLS_DIV_S;
         default:         c = CLS_DIV_U;
      endcase
      return c;
   endfunction

   // hi half = product high word or remainder; lo half = product low word or quotient
   function automatic logic sel_hi(input logic [2:0] op);
      return op[2] ? op[1] : (op[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/aftab_mdu_if.sv
// Request/response bundle between the AFTAB datapath and the multiply/divide unit.
interface aftab_mdu_if #(parameter int WIDTH = 32);
   // Handshake: a request is taken on any rising edge where start=1, abort=0
   // and busy=0 (unit in IDLE or DONE); op/A/B are captured on that edge only.
   // The response is a one-cycle done pulse; result and the flags are valid in
   // that cycle and result holds until the next done. No back-pressure exists.
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             abort;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             dividedByZeroFlag;
   logic             overflowFlag;
   logic [1:0]       dbg_state;

   modport master (
      output start, op, A, B, abort,
      input  busy, done, result, dividedByZeroFlag, overflowFlag, dbg_state
   );

   modport slave (
      input  start, op, A, B, abort,
      output busy, done, result, dividedByZeroFlag, overflowFlag, dbg_state
   );
endinterface

// File: rtl/aftab_mdu_core.sv
// Shared iteration datapath: shift-add multiply and restoring divide on magnitudes.
module aftab_mdu_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic               div_mode,
   input  logic [WIDTH-1:0]   a_mag,
   input  logic [WIDTH-1:0]   b_mag,
   output logic [2*WIDTH-1:0] prod_nx,
   output logic [WIDTH-1:0]   quo_nx,
   output logic [WIDTH-1:0]   rem_nx,
   output logic               last
);
   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH:0]     acc_q, acc_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     trial;
   logic [WIDTH:0]     diff;

   // One iteration per step; mul keeps the whole product in sreg, div keeps the
   // dividend/quotient in the low half and the partial remainder in acc.
   always_comb begin
      sreg_d = sreg_q;
      acc_d  = acc_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      sum    = {1'b0, sreg_q[2*WIDTH-1:WIDTH]} + (sreg_q[0] ? {1'b0, dvs_q} : '0);
      trial  = {acc_q[WIDTH-1:0], sreg_q[WIDTH-1]};
      diff   = trial - {1'b0, dvs_q};
      if (load) begin
         sreg_d = {{WIDTH{1'b0}}, a_mag};
         acc_d  = '0;
         dvs_d  = b_mag;
         cnt_d  = CW'(WIDTH - 1);
      end else if (step) begin
         if (div_mode) begin
            // borrow out of the trial subtract means restore
            acc_d  = diff[WIDTH] ? trial : diff;
            sreg_d = {{WIDTH{1'b0}}, sreg_q[WIDTH-2:0], ~diff[WIDTH]};
         end else begin
            sreg_d = {sum, sreg_q[WIDTH-1:1]};
         end
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg_q <= '0;
         acc_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         acc_q  <= acc_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
      end
   end

   // Post-step values let the top finish in the same cycle as the final step.
   assign prod_nx = sreg_d;
   assign quo_nx  = sreg_d[WIDTH-1:0];
   assign rem_nx  = acc_d[WIDTH-1:0];
   assign last    = (cnt_q == '0);

endmodule

// File: rtl/aftab_mdu.sv
// Iterative RISC-V M-extension multiply/divide unit with shortcuts and a result cache.
module aftab_mdu
   import aftab_mdu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter bit CACHE_EN = 1'b1
) (
   input logic        clk,
   input logic        rst,
   aftab_mdu_if.slave bus
);
   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               dbz_q, dbz_d;
   logic               ovf_q, ovf_d;
   logic               c_valid_q, c_valid_d;
   logic [WIDTH-1:0]   c_a_q, c_a_d;
   logic [WIDTH-1:0]   c_b_q, c_b_d;
   cls_t               c_cls_q, c_cls_d;
   logic [WIDTH-1:0]   c_hi_q, c_hi_d;
   logic [WIDTH-1:0]   c_lo_q, c_lo_d;

   logic               accept, a_neg, b_neg, dbz, ovf, hit;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               core_load, core_step, core_div, core_last;
   logic [2*WIDTH-1:0] core_prod, prod_fix;
   logic [WIDTH-1:0]   core_quo, core_rem, quo_fix, rem_fix, fix_hi, fix_lo;

   // Accept-time decode: magnitudes, sign capture and shortcut detection
   always_comb begin
      accept = (state_q != ST_CALC) && bus.start && !bus.abort;
      a_neg  = a_signed(bus.op) && bus.A[WIDTH-1];
      b_neg  = b_signed(bus.op) && bus.B[WIDTH-1];
      a_mag  = a_neg ? (~bus.A + 1'b1) : bus.A;
      b_mag  = b_neg ? (~bus.B + 1'b1) : bus.B;
      dbz    = is_div(bus.op) && (bus.B == '0);
      ovf    = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
               (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.B == '1);
      hit    = CACHE_EN && c_valid_q && (c_a_q == bus.A) && (c_b_q == bus.B) &&
               (c_cls_q == op_class(bus.op));
   end

   // Sign fix-up of the post-step core values
   always_comb begin
      prod_fix = (sa_q ^ sb_q) ? -core_prod : core_prod;
      quo_fix  = (sa_q ^ sb_q) ? -core_quo : core_quo;
      rem_fix  = sa_q ? -core_rem : core_rem;
      fix_hi   = is_div(op_q) ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = is_div(op_q) ? quo_fix : prod_fix[WIDTH-1:0];
   end

   assign core_load = accept && !(dbz || ovf || hit);
   assign core_step = (state_q == ST_CALC) && !bus.abort;
   assign core_div  = is_div(op_q);

   aftab_mdu_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (core_load),
      .step     (core_step),
      .div_mode (core_div),
      .a_mag    (a_mag),
      .b_mag    (b_mag),
      .prod_nx  (core_prod),
      .quo_nx   (core_quo),
      .rem_nx   (core_rem),
      .last     (core_last)
   );

   // Next-state, result, flag and cache update logic
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      result_d  = result_q;
      dbz_d     = 1'b0;
      ovf_d     = 1'b0;
      c_valid_d = c_valid_q;
      c_a_d     = c_a_q;
      c_b_d     = c_b_q;
      c_cls_d   = c_cls_q;
      c_hi_d    = c_hi_q;
      c_lo_d    = c_lo_q;
      if (bus.abort) c_valid_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (accept) begin
               op_d = bus.op;
               a_d  = bus.A;
               b_d  = bus.B;
               sa_d = a_neg;
               sb_d = b_neg;
               if (dbz) begin
                  state_d  = ST_DONE;
                  result_d = sel_hi(bus.op) ? bus.A : '1;
                  dbz_d    = 1'b1;
               end else if (ovf) begin
                  state_d  = ST_DONE;
                  result_d = sel_hi(bus.op) ? '0 : bus.A;
                  ovf_d    = 1'b1;
               end else if (hit) begin
                  state_d  = ST_DONE;
                  result_d = sel_hi(bus.op) ? c_hi_q : c_lo_q;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (bus.abort) begin
               state_d = ST_IDLE;
            end else if (core_last) begin
               state_d   = ST_DONE;
               result_d  = sel_hi(op_q) ? fix_hi : fix_lo;
               c_valid_d = 1'b1;
               c_a_d     = a_q;
               c_b_d     = b_q;
               c_cls_d   = op_class(op_q);
               c_hi_d    = fix_hi;
               c_lo_d    = fix_lo;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_CALC);
      done_d = (state_d == ST_DONE);
   end

   // FSM state, registered outputs and cache entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_MUL;
         a_q       <= '0;
         b_q       <= '0;
         sa_q      <= 1'b0;
         sb_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
         dbz_q     <= 1'b0;
         ovf_q     <= 1'b0;
         c_valid_q <= 1'b0;
         c_a_q     <= '0;
         c_b_q     <= '0;
         c_cls_q   <= CLS_MUL_SS;
         c_hi_q    <= '0;
         c_lo_q    <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sa_q      <= sa_d;
         sb_q      <= sb_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
         dbz_q     <= dbz_d;
         ovf_q     <= ovf_d;
         c_valid_q <= c_valid_d;
         c_a_q     <= c_a_d;
         c_b_q     <= c_b_d;
         c_cls_q   <= c_cls_d;
         c_hi_q    <= c_hi_d;
         c_lo_q    <= c_lo_d;
      end
   end

   assign bus.busy              = busy_q;
   assign bus.done              = done_q;
   assign bus.result            = result_q;
   assign bus.dividedByZeroFlag = dbz_q;
   assign bus.overflowFlag      = ovf_q;
   assign bus.dbg_state         = state_q;

endmodule

// File: tb/tb_aftab_mdu.sv
// Self-checking bench for aftab_mdu (WIDTH=32) with an expected-result queue.
module tb_aftab_mdu;
   import aftab_mdu_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   start_cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [W-1:0] exp_q[$];
   logic [1:0]   expf_q[$];
   int           expl_q[$];

   aftab_mdu_if #(.WIDTH(W)) bus ();

   aftab_mdu #(.WIDTH(W), .CACHE_EN(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // reference model built on native integer arithmetic
   function automatic logic [W-1:0] model_res(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      longint      sa, sb, p;
      logic [63:0] pu;
      logic [W-1:0] r;
      logic        ov;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r  = '0;
      case (op)
         OP_MUL:    begin p = sa * sb; r = p[31:0]; end
         OP_MULH:   begin p = sa * sb; r = p[63:32]; end
         OP_MULHSU: begin p = sa * longint'({32'h0, b}); r = p[63:32]; end
         OP_MULHU:  begin pu = {32'h0, a} * {32'h0, b}; r = pu[63:32]; end
         OP_DIV:    if (b == 0) r = '1; else if (ov) r = a; else r = $signed(a) / $signed(b);
         OP_DIVU:   if (b == 0) r = '1; else r = a / b;
         OP_REM:    if (b == 0) r = a; else if (ov) r = '0; else r = $signed(a) % $signed(b);
         default:   if (b == 0) r = a; else r = a % b;
      endcase
      return r;
   endfunction

   // drive one request at the current negedge; returns at the negedge of cycle 1
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e, input bit dbz, input bit ovf, input int lat,
                        input bit track);
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      start_cyc = cyc;
      if (track) begin
         exp_q.push_back(e);
         expf_q.push_back({dbz, ovf});
         expl_q.push_back(lat);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.A     = $urandom;
      bus.B     = $urandom;
      bus.op    = 3'($urandom_range(0, 7));
      check_eq("busy_cycle1", bus.busy, (lat > 1));
   endtask

   // wait (bounded) for done, then pop and compare; returns at the done negedge
   task automatic wait_done(input int budget);
      int           i;
      logic [W-1:0] e;
      logic [1:0]   f;
      int           l;
      i = 0;
      while (!bus.done && i < budget) begin
         @(negedge clk);
         i++;
      end
      e = exp_q.pop_front();
      f = expf_q.pop_front();
      l = expl_q.pop_front();
      check_eq("done_seen", bus.done, 1'b1);
      if (bus.done) begin
         check_eq("result", bus.result, e);
         check_eq("dbz_flag", bus.dividedByZeroFlag, f[1]);
         check_eq("ovf_flag", bus.overflowFlag, f[0]);
         check_eq("latency", cyc - start_cyc, l);
         check_eq("busy_at_done", bus.busy, 1'b0);
      end
   endtask

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e, input bit dbz, input bit ovf, input int lat);
      @(negedge clk);
      issue(op, a, b, e, dbz, ovf, lat, 1'b1);
      wait_done(40);
   endtask

   task automatic check_quiet(input string tag);
      int n_done;
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      check_eq(tag, n_done, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"}, bus.busy, 1'b0);
      check_eq({tag, "_done"}, bus.done, 1'b0);
      check_eq({tag, "_result"}, bus.result, '0);
      check_eq({tag, "_dbz"}, bus.dividedByZeroFlag, 1'b0);
      check_eq({tag, "_ovf"}, bus.overflowFlag, 1'b0);
      check_eq({tag, "_state"}, bus.dbg_state, ST_IDLE);
   endtask

   initial begin
      logic [2:0]   r_op;
      logic [W-1:0] r_a, r_b;
      bit           r_dbz, r_ovf;

      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.op    = OP_MUL;
      bus.A     = '0;
      bus.B     = '0;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // multiply, then cache hit on the other half
      run_op(OP_MUL,    32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0, 33);
      run_op(OP_MULH,   32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
      run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
      run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);

      // signed divide, cached remainder, unsigned remainder iterates
      run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, 33);
      run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
      run_op(OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1,         1'b0, 1'b0, 33);

      // divide by zero and signed overflow shortcuts
      run_op(OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
      run_op(OP_REM,  32'd100, 32'd0, 32'd100,       1'b1, 1'b0, 1);
      run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1);
      run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b1, 1);

      // abort mid-divide invalidates the cache and produces no done
      run_op(OP_DIV, 32'd1000, 32'd7, 32'd142, 1'b0, 1'b0, 33);
      @(negedge clk);
      issue(OP_DIVU, 32'd1000, 32'd7, '0, 1'b0, 1'b0, 33, 1'b0);
      while (cyc - start_cyc < 10) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check_eq("abort_busy", bus.busy, 1'b0);
      check_eq("abort_done", bus.done, 1'b0);
      check_quiet("abort_no_done");
      run_op(OP_DIV,  32'd1000, 32'd7, 32'd142, 1'b0, 1'b0, 33);
      run_op(OP_DIVU, 32'd1000, 32'd7, 32'd142, 1'b0, 1'b0, 33);

      // reset mid-multiply, then back-to-back start in the DONE cycle
      run_op(OP_MUL, 32'd12345, 32'd678, 32'd8369910, 1'b0, 1'b0, 33);
      @(negedge clk);
      issue(OP_MULHU, 32'd12345, 32'd678, '0, 1'b0, 1'b0, 33, 1'b0);
      while (cyc - start_cyc < 5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midcalc_reset");
      rst = 1'b0;
      check_quiet("reset_no_done");
      run_op(OP_MUL, 32'd12345, 32'd678, 32'd8369910, 1'b0, 1'b0, 33);
      issue(OP_MULH, 32'd12345, 32'd678, 32'd0, 1'b0, 1'b0, 1, 1'b1);
      wait_done(40);
      issue(OP_DIVU, 32'd9, 32'd4, 32'd2, 1'b0, 1'b0, 33, 1'b1);
      wait_done(40);

      // random ops against the model
      for (int i = 0; i < 12; i++) begin
         r_op = 3'($urandom_range(0, 7));
         r_a  = $urandom;
         r_b  = (i % 4 == 3) ? '0 : W'($urandom);
         if (i == 5) begin
            r_op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_REM;
            r_a  = 32'h8000_0000;
            r_b  = 32'hFFFF_FFFF;
         end
         r_dbz = r_op[2] && (r_b == 0);
         r_ovf = ((r_op == OP_DIV) || (r_op == OP_REM)) && (r_a == 32'h8000_0000) &&
                 (r_b == 32'hFFFF_FFFF);
         run_op(r_op, r_a, r_b, model_res(r_op, r_a, r_b), r_dbz, r_ovf,
                (r_dbz || r_ovf) ? 1 : 33);
      end

      check_eq("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/aftab_mdu.md
# aftab_mdu

Parametrised iterative multiply/divide unit for the AFTAB datapath, covering the full RISC-V M-extension op set.
- Accepts one operation per start pulse, decoded from a 3-bit funct3-style op code.
- Computes on operand magnitudes with a shared shift register, then applies sign fix-up.
- Returns a single WIDTH-bit result with a one-cycle done pulse.
- Adds RISC-V divide-by-zero and overflow semantics, abort, and a one-entry result cache so that MULH→MUL or DIV→REM pairs on the same operands finish in one cycle.

## Interface
Parameters:
- WIDTH, 32, operand and result width (≥4)
- CACHE_EN, 1, enables the last-result cache (0 = every op iterates)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE state
- op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- A  in  WIDTH  rs1 / dividend
- B  in  WIDTH  rs2 / divisor
- abort  in  1  cancel the in-flight operation
- busy  out  1  operation in progress; start ignored while high
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  result, held until the next done
- dividedByZeroFlag  out  1  valid with done; set for DIV/DIVU/REM/REMU with B=0
- overflowFlag  out  1  valid with done; set for DIV/REM with A=2^(WIDTH-1) and B=all-ones

## Operation
- FSM states: IDLE, CALC, DONE.
- Accept: in IDLE or DONE with start=1, op/A/B are latched. Operands that are signed for this op are converted to magnitudes, and sign bits are recorded:
  - MUL/MULH: A and B signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - DIV/REM: both signed.
- Shortcut checks at accept, in priority order: divide-by-zero, overflow, cache hit. Any hit goes directly to DONE with no CALC cycles.
  - Divide-by-zero: quotient = all-ones, remainder = A. dividedByZeroFlag=1.
  - Overflow: quotient = A, remainder = 0. overflowFlag=1.
  - Cache hit (CACHE_EN=1): the stored A and B match, the stored class matches (mul-signed-signed, mul-su, mul-uu, div-signed, div-unsigned), and the entry is valid. The half for the new op is selected from the stored pair.
- CALC, WIDTH cycles, counter WIDTH-1 down to 0:
  - Multiply: radix-2 shift-add into a 2·WIDTH product register.
  - Divide: restoring, one quotient bit per cycle. The remainder register is WIDTH+1 bits wide to hold the trial-subtract borrow.
- Exit from CALC to DONE, in the same cycle as the final iteration (combinational fix-up):
  - The product is negated if sA^sB.
  - The quotient is negated if sA^sB; the remainder is negated if sA.
  - Both halves (hi/lo or quotient/remainder) are written to the cache with the operands and class, and the entry is marked valid.
  - result is selected as follows: MUL → lo; MULH/MULHSU/MULHU → hi; DIV/DIVU → quotient; REM/REMU → remainder.
- DONE: done=1 for exactly one cycle, then return to IDLE. A start in DONE is accepted, which allows back-to-back ops.
- abort=1 in CALC: next state IDLE, no done, cache invalidated. abort in IDLE/DONE has no effect on done but still invalidates the cache. abort has priority over start.
- Flags are zero except in the DONE cycle of the relevant shortcut.

## Timing
- Cycle 0 is the cycle in which start is sampled.
- Iterative op: busy=1 in cycles 1..WIDTH (CALC); done=1 in cycle WIDTH+1. Latency is WIDTH+1.
- Shortcut op: done=1 in cycle 1; busy stays 0.
- result changes only on the edge entering DONE and otherwise holds its value.
- Reset values: busy=0, done=0, result=0, both flags 0, state IDLE, cache invalid.
- Reset mid-CALC: immediate return to IDLE, no done pulse, cache invalid.
- A and B may change after cycle 0 without affecting the in-flight op.

## Structure
- Package aftab_mdu_pkg holds:
  - the op encodings as localparams,
  - the FSM state encoding,
  - the op-class encoding used for cache matching,
  - helper functions is_div(op), a_signed(op), b_signed(op).
- Sub-module aftab_mdu_core holds the shared iteration datapath: the 2·WIDTH shift register, the WIDTH+1 remainder/accumulator, the counter and the adder/subtractor. It is controlled by mode and step signals from the top-level FSM. The cache, shortcuts, sign fix-up and result mux stay in the top level.

## Test plan
All scenarios use WIDTH=32.
- MUL A=7, B=0xFFFFFFFD → result 0xFFFFFFEB, done in cycle 33. Then MULH on the same operands → 0xFFFFFFFF, done in cycle 1 (cache hit).
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF → 0xFFFFFFFF. Each takes 33 cycles, since a class mismatch means no cache hit.
- DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD at cycle 33. Then REM on the same operands → 0xFFFFFFFF at cycle 1. Then REMU → iterates, result 1.
- DIVU 100/0 → 0xFFFFFFFF with dividedByZeroFlag, cycle 1. REM 100/0 → 100.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 with overflowFlag, cycle 1. REM on the same operands → 0 with overflowFlag.
- Assert abort at cycle 10 of a DIV → no done and busy=0 next cycle; repeating the same DIV iterates fully. In a separate run, assert rst at cycle 5 of a MUL → all outputs at their reset values; a back-to-back start in the DONE cycle is accepted.
